// File: rtl/div_share_ctrl_pkg.sv
// Shared definitions for the divider-sharing controller: FSM state
// encoding, lane identifiers and the default data width.
package div_share_ctrl_pkg;

  localparam int DEF_DATA_W = 32;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/div_share_ctrl_if.sv
// Bundle of the lane request/response signals and the divider handshake.
// slave  : the controller's view (serves the lanes, drives the divider).
// master : the environment's view (the two lanes plus the divider itself).
interface div_share_ctrl_if
  import div_share_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              flush;

  logic              req0_i;
  logic              req1_i;
  logic              signed0_i;
  logic              signed1_i;
  logic              mod0_i;
  logic              mod1_i;
  logic [DATA_W-1:0] dividend0_i;
  logic [DATA_W-1:0] dividend1_i;
  logic [DATA_W-1:0] divisor0_i;
  logic [DATA_W-1:0] divisor1_i;

  logic              resp_valid0_o;
  logic              resp_valid1_o;
  logic [DATA_W-1:0] result_o;
  logic              dbz_o;
  logic              busy_o;

  logic              div_start_o;
  logic              div_signed_o;
  logic [DATA_W-1:0] div_dividend_o;
  logic [DATA_W-1:0] div_divisor_o;
  logic              div_done_i;
  logic [DATA_W-1:0] div_quotient_i;
  logic [DATA_W-1:0] div_remainder_i;
  logic              div_dbz_i;

  modport slave (
    input  flush,
    input  req0_i, req1_i, signed0_i, signed1_i, mod0_i, mod1_i,
    input  dividend0_i, dividend1_i, divisor0_i, divisor1_i,
    output resp_valid0_o, resp_valid1_o, result_o, dbz_o, busy_o,
    output div_start_o, div_signed_o, div_dividend_o, div_divisor_o,
    input  div_done_i, div_quotient_i, div_remainder_i, div_dbz_i
  );

  modport master (
    output flush,
    output req0_i, req1_i, signed0_i, signed1_i, mod0_i, mod1_i,
    output dividend0_i, dividend1_i, divisor0_i, divisor1_i,
    input  resp_valid0_o, resp_valid1_o, result_o, dbz_o, busy_o,
    input  div_start_o, div_signed_o, div_dividend_o, div_divisor_o,
    output div_done_i, div_quotient_i, div_remainder_i, div_dbz_i
  );

endinterface

// File: rtl/div_share_ctrl_arb.sv
// div_rr_arb: two-way arbiter for the shared divider. With fixed priority
// lane 0 (the older instruction) wins every tie; otherwise the tie goes to
// the lane named by the round-robin pointer.
module div_rr_arb
  import div_share_ctrl_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       lane0_priority,
  input  logic       rr_ptr,
  output logic [1:0] gnt
);

  // One-hot grant; a lane with its request low is never granted.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path can leave it unassigned and infer a latch.
    gnt = 2'b00;
    if (req0 && req1) begin
      gnt = (lane0_priority || rr_ptr == LANE0) ? 2'b01 : 2'b10;
    end else begin
      gnt = {req1, req0};
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one multi-cycle divider between the two ALU lanes.
// Grants one lane, latches its operands, pulses div_start, waits for
// div_done and returns quotient or remainder to that lane. Flush or cancel
// while the divider is running drains it before it can be reused.
// Optional feature: DIV_RESULT_CACHE_EN adds a one-entry result cache that
// answers a repeated operation straight from IDLE without using the divider.
module div_share_ctrl
  import div_share_ctrl_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter bit LANE0_PRIORITY = 1'b1
) (
  input logic             clk,
  input logic             rst,
  div_share_ctrl_if.slave bus
);

  state_e            state_q, state_d;

  logic              lane_q;
  logic              signed_q;
  logic              mod_q;
  logic [DATA_W-1:0] dividend_q;
  logic [DATA_W-1:0] divisor_q;
  logic [DATA_W-1:0] result_q;
  logic              dbz_q;
  logic              rr_ptr_q;

  logic [1:0]        gnt;
  logic              any_gnt;
  logic              gnt_lane;
  logic              sel_signed;
  logic              sel_mod;
  logic [DATA_W-1:0] sel_dividend;
  logic [DATA_W-1:0] sel_divisor;
  logic              lane_req;
  logic              abort;
  logic              cache_hit;

  div_rr_arb u_arb (
    .req0           (bus.req0_i),
    .req1           (bus.req1_i),
    .lane0_priority (LANE0_PRIORITY),
    .rr_ptr         (rr_ptr_q),
    .gnt            (gnt)
  );

  // Grant is one-hot, so bit 1 is directly the granted lane id.
  assign any_gnt      = |gnt;
  assign gnt_lane     = gnt[1];
  assign sel_signed   = gnt_lane ? bus.signed1_i   : bus.signed0_i;
  assign sel_mod      = gnt_lane ? bus.mod1_i      : bus.mod0_i;
  assign sel_dividend = gnt_lane ? bus.dividend1_i : bus.dividend0_i;
  assign sel_divisor  = gnt_lane ? bus.divisor1_i  : bus.divisor0_i;

  // The granted lane withdrawing its request is a cancel.
  assign lane_req = (lane_q == LANE1) ? bus.req1_i : bus.req0_i;
  assign abort    = bus.flush || !lane_req;

`ifdef DIV_RESULT_CACHE_EN
  logic              c_valid_q;
  logic              c_signed_q;
  logic [DATA_W-1:0] c_dividend_q;
  logic [DATA_W-1:0] c_divisor_q;
  logic [DATA_W-1:0] c_quot_q;
  logic [DATA_W-1:0] c_rem_q;
  logic              c_dbz_q;

  // Capture every divider completion, drained ones included; only rst clears.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the cache entry is reset explicitly; a stale valid bit after rst
    // would answer with a result for operands that were never divided.
    if (rst) begin
      c_valid_q    <= 1'b0;
      c_signed_q   <= 1'b0;
      c_dividend_q <= '0;
      c_divisor_q  <= '0;
      c_quot_q     <= '0;
      c_rem_q      <= '0;
      c_dbz_q      <= 1'b0;
    end else if (bus.div_done_i && (state_q == ST_WAIT || state_q == ST_DRAIN)) begin
      c_valid_q    <= 1'b1;
      c_signed_q   <= signed_q;
      c_dividend_q <= dividend_q;
      c_divisor_q  <= divisor_q;
      c_quot_q     <= bus.div_quotient_i;
      c_rem_q      <= bus.div_remainder_i;
      c_dbz_q      <= bus.div_dbz_i;
    end
  end

  assign cache_hit = c_valid_q && (c_signed_q == sel_signed) &&
                     (c_dividend_q == sel_dividend) && (c_divisor_q == sel_divisor);
`else
  assign cache_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.flush && any_gnt) begin
          state_d = cache_hit ? ST_RESP : ST_ISSUE;
        end
      end
      // The start pulse goes out regardless; a kill seen here still has to
      // wait for the divider to finish, hence DRAIN.
      ST_ISSUE: state_d = abort ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (abort) begin
          state_d = bus.div_done_i ? ST_IDLE : ST_DRAIN;
        end else if (bus.div_done_i) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_DRAIN: begin
        if (bus.div_done_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the granted lane's request when leaving IDLE; held until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q     <= LANE0;
      signed_q   <= 1'b0;
      mod_q      <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
    end else if (state_q == ST_IDLE && state_d != ST_IDLE) begin
      lane_q     <= gnt_lane;
      signed_q   <= sel_signed;
      mod_q      <= sel_mod;
      dividend_q <= sel_dividend;
      divisor_q  <= sel_divisor;
    end
  end

  // Result register: loaded from the divider on completion, or from the cache on a hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else if (state_q == ST_WAIT && state_d == ST_RESP) begin
      result_q <= mod_q ? bus.div_remainder_i : bus.div_quotient_i;
      dbz_q    <= bus.div_dbz_i;
    end
`ifdef DIV_RESULT_CACHE_EN
    else if (state_q == ST_IDLE && state_d == ST_RESP) begin
      result_q <= sel_mod ? c_rem_q : c_quot_q;
      dbz_q    <= c_dbz_q;
    end
`endif
  end

  // Round-robin pointer: the lane just served drops to lowest priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= LANE0;
    end else if (state_q == ST_RESP) begin
      rr_ptr_q <= (lane_q == LANE0) ? LANE1 : LANE0;
    end
  end

  // Outputs decode from registered state, so async reset clears them at once.
  assign bus.busy_o         = (state_q != ST_IDLE);
  assign bus.div_start_o    = (state_q == ST_ISSUE);
  assign bus.div_signed_o   = signed_q;
  assign bus.div_dividend_o = dividend_q;
  assign bus.div_divisor_o  = divisor_q;
  assign bus.result_o       = result_q;
  assign bus.dbz_o          = dbz_q;
  assign bus.resp_valid0_o  = (state_q == ST_RESP) && (lane_q == LANE0) && !bus.flush;
  assign bus.resp_valid1_o  = (state_q == ST_RESP) && (lane_q == LANE1) && !bus.flush;

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Shares one multi-cycle divider (start/done handshake) between the two ALU lanes of the dual-issue execute stage.
- Accepts divide/modulo requests from lane 0 and lane 1 and grants one at a time.
- Latches operands, pulses the divider start, waits for done, and returns quotient or remainder to the granted lane.
- Discards in-flight results on pipeline flush or requester cancel, and drains the divider before reuse.

Parameters:
- DATA_W, 32, operand and result width.
- LANE0_PRIORITY, 1: 1 = lane 0 (older instruction) always wins a tie; 0 = round-robin between lanes.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush; kills any outstanding request
- req0_i / req1_i  in  1  lane request; held high with stable operands until that lane's resp_valid
- signed0_i / signed1_i  in  1  signed operation
- mod0_i / mod1_i  in  1  1 = return remainder, 0 = return quotient
- dividend0_i / dividend1_i  in  DATA_W  dividend
- divisor0_i / divisor1_i  in  DATA_W  divisor
- resp_valid0_o / resp_valid1_o  out  1  one-cycle result strobe to the lane
- result_o  out  DATA_W  quotient or remainder (shared; qualified by resp_valid)
- dbz_o  out  1  divide-by-zero flag for the returned result
- busy_o  out  1  FSM not in IDLE
- div_start_o  out  1  one-cycle start pulse to the divider
- div_signed_o  out  1  signed-op to the divider
- div_dividend_o / div_divisor_o  out  DATA_W  latched operands
- div_done_i  in  1  divider completion pulse
- div_quotient_i / div_remainder_i  in  DATA_W  divider results
- div_dbz_i  in  1  divider divide-by-zero flag

Behaviour:
- Reset: state IDLE; all outputs 0; operand and result registers 0; round-robin pointer = lane 0.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - If flush is high, stay in IDLE.
  - Otherwise pick a lane among asserted reqs per LANE0_PRIORITY.
  - Latch the granted lane's id, signed, mod and operands, then go to ISSUE.
- ISSUE:
  - Assert div_start_o for exactly one cycle, then go to WAIT.
  - div_dividend_o, div_divisor_o and div_signed_o come from the latch and stay stable until leaving WAIT/DRAIN.
- WAIT:
  - On div_done_i, register result = mod ? remainder : quotient, plus dbz, then go to RESP.
  - On flush, or the granted lane dropping its req, go to DRAIN; a same-cycle done with flush/cancel goes straight to IDLE and the result is discarded.
- RESP:
  - resp_validN_o = 1 for the granted lane only, gated combinationally by !flush.
  - Return to IDLE next cycle.
  - Round-robin pointer moves to the other lane after each RESP.
- DRAIN: ignore requests; on div_done_i go to IDLE with no response.
- Latency: req seen in IDLE at cycle 0 → start at cycle 1 → resp at done cycle + 1.
- A new grant is possible in the cycle after RESP (IDLE samples it).
- Request rules:
  - Only one resp_valid is ever high in a cycle.
  - A lane whose req is low is never granted.
  - Never issue a second start while the divider is busy.
- busy_o = (state != IDLE).
- Reset mid-operation returns to IDLE immediately; the divider is reset by the same rst, so no drain is needed.

Optional Feature:
- Macro DIV_RESULT_CACHE_EN.
- Defined:
  - Keep a one-entry cache {valid, signed, dividend, divisor, quotient, remainder, dbz}, written on every div_done_i (including in DRAIN).
  - In IDLE, a granted request matching signed/dividend/divisor with valid=1 goes directly to RESP with cached data: latency 1 cycle, no div_start_o.
  - Cache is cleared by rst only; flush does not clear it.
- Undefined: no cache logic; every request goes through ISSUE.

Decomposition:
- Shared package (defines header): FSM state encodings (3-bit), lane-id constants LANE0=0 / LANE1=1, DATA_W default.
- One natural sub-module: div_rr_arb, a 2-way arbiter taking req0/req1, priority mode and pointer, and giving a one-hot grant.
- FSM and datapath stay in div_share_ctrl.

Test Plan:
- Lane0 only, signed, 100 / -7, mod=0 → div_start_o one pulse; resp_valid0_o with result_o=-14 (0xFFFFFFF2), dbz_o=0.
- Both lanes request (lane0 7 % 3, lane1 9 / 2), LANE0_PRIORITY=1 → lane0 resp 1 first, then lane1 resp 4; never both strobes together.
- Lane1 unsigned 5 / 0 → dbz_o=1; result_o equals div_quotient_i passthrough (0xFFFFFFFF from the divider model).
- Flush 2 cycles after start → state DRAIN; no resp_valid; a new lane0 req is accepted only after div_done_i; no second start overlaps.
- rst asserted in WAIT → all outputs 0 within the same cycle (asynchronous); busy_o=0.
- With DIV_RESULT_CACHE_EN: repeat 100 / 7 unsigned → second resp 1 cycle after req, result 14, no div_start_o.
